// File: rtl/viterbi_sipo_ctrl_if.sv
// ============================================================================
// Module   : viterbi_sipo_ctrl_if
// Brief    : Bit-stream, SIPO and word-output handshake bundle for the
//            Viterbi SIPO frame controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface viterbi_sipo_ctrl_if #(
    parameter int WORD_W = 8
) ();
    logic              i_frame_start;
    logic              i_bit_valid;
    logic              i_bit;
    logic              o_bit_ready;
    logic              o_sipo_start;
    logic              o_sipo_data;
    logic              i_sipo_done;
    logic [WORD_W-1:0] i_sipo_data;
    logic              o_word_valid;
    logic [WORD_W-1:0] o_word_data;
    logic              o_word_last;
    logic              i_word_ready;
    logic              o_frame_done;
    logic              o_busy;
    logic              o_err_timeout;

    // Controller side
    modport master (
        input  i_frame_start, i_bit_valid, i_bit, i_sipo_done, i_sipo_data, i_word_ready,
        output o_bit_ready, o_sipo_start, o_sipo_data, o_word_valid, o_word_data,
        output o_word_last, o_frame_done, o_busy, o_err_timeout
    );

    // Environment side (bit source, SIPO, word sink)
    modport slave (
        output i_frame_start, i_bit_valid, i_bit, i_sipo_done, i_sipo_data, i_word_ready,
        input  o_bit_ready, o_sipo_start, o_sipo_data, o_word_valid, o_word_data,
        input  o_word_last, o_frame_done, o_busy, o_err_timeout
    );
endinterface

`default_nettype wire

// File: rtl/viterbi_sipo_ctrl.sv
// ============================================================================
// Module   : viterbi_sipo_ctrl
// Brief    : Frame sequencer for the 1-bit SIPO deserializer: gates serial bits
//            into the SIPO, buffers each word and delivers it with last/done.
//            Optional SIPO-done watchdog enabled by macro SIPO_CTRL_WDT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module viterbi_sipo_ctrl #(
    parameter int WORD_W      = 8,
    parameter int FRAME_WORDS = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    viterbi_sipo_ctrl_if.master  bus
);

    localparam int c_BIT_CNT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int c_WORD_CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [c_BIT_CNT_W-1:0]  c_BIT_LAST  = c_BIT_CNT_W'(WORD_W - 1);
    localparam logic [c_WORD_CNT_W-1:0] c_WORD_LAST = c_WORD_CNT_W'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SHIFT     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_HOLD      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                  r_state_q,     w_state_d;
    logic [c_BIT_CNT_W-1:0]  r_bit_cnt_q,   w_bit_cnt_d;
    logic [c_WORD_CNT_W-1:0] r_word_cnt_q,  w_word_cnt_d;
    logic [WORD_W-1:0]       r_word_data_q, w_word_data_d;

    logic w_accept;
    logic w_is_last;

    assign w_accept  = (r_state_q == S_SHIFT) && bus.i_bit_valid;
    assign w_is_last = (r_word_cnt_q == c_WORD_LAST);

`ifdef SIPO_CTRL_WDT_EN
    localparam int c_WDT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_WDT_W-1:0] c_WDT_LAST = c_WDT_W'(TIMEOUT - 1);

    logic [c_WDT_W-1:0] r_wdt_q, w_wdt_d;
    logic               r_err_q, w_err_d;
    logic               w_wdt_expired;

    // Expires on the TIMEOUT-th WAIT_DONE cycle without a done; a done on that
    // same cycle still wins.
    assign w_wdt_expired = (r_state_q == S_WAIT_DONE) && !bus.i_sipo_done &&
                           (r_wdt_q == c_WDT_LAST);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        w_state_d     = r_state_q;
        w_bit_cnt_d   = r_bit_cnt_q;
        w_word_cnt_d  = r_word_cnt_q;
        w_word_data_d = r_word_data_q;
`ifdef SIPO_CTRL_WDT_EN
        w_wdt_d       = '0;
        w_err_d       = 1'b0;
`endif
        case (r_state_q)
            S_IDLE: begin
                if (bus.i_frame_start) begin
                    w_state_d    = S_SHIFT;
                    w_bit_cnt_d  = '0;
                    w_word_cnt_d = '0;
                end
            end
            S_SHIFT: begin
                if (w_accept) begin
                    if (r_bit_cnt_q == c_BIT_LAST) begin
                        w_bit_cnt_d = '0;
                        w_state_d   = S_WAIT_DONE;
                    end else begin
                        w_bit_cnt_d = r_bit_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT_DONE: begin
`ifdef SIPO_CTRL_WDT_EN
                w_wdt_d = r_wdt_q + 1'b1;
`endif
                if (bus.i_sipo_done) begin
                    w_word_data_d = bus.i_sipo_data;
                    w_state_d     = S_HOLD;
                end
`ifdef SIPO_CTRL_WDT_EN
                else if (w_wdt_expired) begin
                    w_state_d    = S_IDLE;
                    w_bit_cnt_d  = '0;
                    w_word_cnt_d = '0;
                    w_err_d      = 1'b1;
                end
`endif
            end
            S_HOLD: begin
                // Single word buffer: the next word is not shifted until this
                // one has been taken downstream.
                if (bus.i_word_ready) begin
                    if (w_is_last) begin
                        w_state_d = S_DONE;
                    end else begin
                        w_word_cnt_d = r_word_cnt_q + 1'b1;
                        w_state_d    = S_SHIFT;
                    end
                end
            end
            S_DONE: begin
                w_state_d    = S_IDLE;
                w_word_cnt_d = '0;
            end
            default: begin
                w_state_d    = S_IDLE;
                w_bit_cnt_d  = '0;
                w_word_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q     <= S_IDLE;
            r_bit_cnt_q   <= '0;
            r_word_cnt_q  <= '0;
            r_word_data_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_bit_cnt_q   <= w_bit_cnt_d;
            r_word_cnt_q  <= w_word_cnt_d;
            r_word_data_q <= w_word_data_d;
        end
    end

`ifdef SIPO_CTRL_WDT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wdt_q <= '0;
            r_err_q <= 1'b0;
        end else begin
            r_wdt_q <= w_wdt_d;
            r_err_q <= w_err_d;
        end
    end

    assign bus.o_err_timeout = r_err_q;
`else
    assign bus.o_err_timeout = 1'b0;
`endif

    assign bus.o_bit_ready  = (r_state_q == S_SHIFT);
    assign bus.o_sipo_start = w_accept;
    assign bus.o_sipo_data  = (r_state_q == S_SHIFT) && bus.i_bit;
    assign bus.o_word_valid = (r_state_q == S_HOLD);
    assign bus.o_word_data  = r_word_data_q;
    assign bus.o_word_last  = (r_state_q == S_HOLD) && w_is_last;
    assign bus.o_frame_done = (r_state_q == S_DONE);
    assign bus.o_busy       = (r_state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_viterbi_sipo_ctrl.sv
// ============================================================================
// Module   : tb_viterbi_sipo_ctrl
// Brief    : Self-checking bench for viterbi_sipo_ctrl with a behavioural SIPO
//            and a frame-level reference model. Honors SIPO_CTRL_WDT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_viterbi_sipo_ctrl;

    localparam int W  = 8;
    localparam int FW = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    viterbi_sipo_ctrl_if #(.WORD_W(W)) bus ();

    viterbi_sipo_ctrl #(.WORD_W(W), .FRAME_WORDS(FW), .TIMEOUT(TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cycle = 0;

    // Samples of DUT outputs taken mid-cycle, before the active edge
    logic         s_bit_ready, s_start, s_sdata, s_valid, s_last, s_fdone, s_busy, s_err;
    logic [W-1:0] s_data;
    int           s_cyc;

    // Behavioural SIPO state
    logic [W-1:0] m_sh = '0;
    int           m_cnt = 0;
    int           m_dly = 0;
    bit           m_suppress = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        bit fired;
        @(negedge clk);
        s_bit_ready = bus.o_bit_ready;  s_start = bus.o_sipo_start;
        s_sdata     = bus.o_sipo_data;  s_valid = bus.o_word_valid;
        s_last      = bus.o_word_last;  s_fdone = bus.o_frame_done;
        s_busy      = bus.o_busy;       s_err   = bus.o_err_timeout;
        s_data      = bus.o_word_data;  s_cyc   = cycle;
        @(posedge clk);
        #1;
        cycle++;
        fired = 1'b0;
        bus.i_sipo_done = 1'b0;
        bus.i_sipo_data = W'($urandom);
        if (rst) begin
            m_sh = '0; m_cnt = 0; m_dly = 0;
        end else begin
            if (m_dly > 0) begin
                m_dly--;
                if (m_dly == 0 && !m_suppress) begin
                    bus.i_sipo_done = 1'b1;
                    bus.i_sipo_data = m_sh;
                    fired = 1'b1;
                end
            end
            if (s_start) begin
                m_sh = {s_sdata, m_sh[W-1:1]};
                m_cnt++;
                if (m_cnt == W) begin
                    m_cnt = 0;
                    m_dly = $urandom_range(3, 1);
                end
            end
            // Stray done pulses while the controller cannot be in WAIT_DONE
            if (!fired && m_dly == 0 && !m_suppress && $urandom_range(3) == 0)
                bus.i_sipo_done = 1'b1;
        end
    endtask

    // Drives one frame and checks it against the expected word list.
    task automatic run_frame(input logic [W-1:0] words [FW], input int gap_pct, input bit alt,
                             input int ready_pct, input int stall_idx, input int stall_len,
                             input bit mid_start);
        int bit_idx = 0, got = 0, hs_cyc = -100, budget = 0, stall_left = stall_len;
        int n_start = 0, n_proto = 0;
        bit done_seen = 1'b0, mid_done = 1'b0;
        bus.i_frame_start = 1'b1; bus.i_bit_valid = 1'b0; bus.i_word_ready = 1'b0;
        cyc();
        bus.i_frame_start = 1'b0;
        while (!done_seen && budget < 3000) begin
            budget++;
            if (bit_idx < FW * W)
                bus.i_bit_valid = alt ? ((budget % 2) == 1) : ($urandom_range(99) >= gap_pct);
            else
                bus.i_bit_valid = 1'b0;
            bus.i_bit = bus.i_bit_valid ? words[bit_idx / W][bit_idx % W] : 1'($urandom);
            bus.i_word_ready = ($urandom_range(99) >= ready_pct);
            if (got == stall_idx && stall_left > 0) bus.i_word_ready = 1'b0;
            bus.i_frame_start = mid_start && (got == 1) && !mid_done;
            if (bus.i_frame_start) mid_done = 1'b1;
            cyc();
            bus.i_frame_start = 1'b0;
            if (s_bit_ready && bus.i_bit_valid) bit_idx++;
            if (s_start !== (s_bit_ready && bus.i_bit_valid)) n_proto++;
            if (s_start && (s_sdata !== bus.i_bit)) n_proto++;
            if (s_start) n_start++;
            if (s_valid && s_bit_ready) n_proto++;
            if (s_last && !s_valid) n_proto++;
            if (s_err) n_proto++;
            if (s_valid && got == stall_idx && stall_left > 0) begin
                check("stall_data", 32'(s_data), 32'(words[stall_idx]));
                check("stall_bit_ready", 32'(s_bit_ready), 32'(0));
                stall_left--;
            end
            if (s_valid && bus.i_word_ready) begin
                check($sformatf("word%0d_data", got), 32'(s_data), 32'(words[got]));
                check($sformatf("word%0d_last", got), 32'(s_last), 32'(got == FW - 1));
                got++;
                hs_cyc = s_cyc;
            end
            if (s_fdone) begin
                check("frame_done_latency", 32'(s_cyc), 32'(hs_cyc + 1));
                check("frame_done_words", 32'(got), 32'(FW));
                check("frame_done_busy", 32'(s_busy), 32'(1));
                done_seen = 1'b1;
            end
        end
        check("frame_done_seen", 32'(done_seen), 32'(1));
        bus.i_bit_valid = 1'b0; bus.i_word_ready = 1'b0;
        cyc();
        check("idle_busy", 32'(s_busy), 32'(0));
        check("idle_valid", 32'(s_valid), 32'(0));
        check("sipo_start_count", 32'(n_start), 32'(FW * W));
        check("protocol_errors", 32'(n_proto), 32'(0));
        if (stall_len > 0) check("stall_consumed", 32'(stall_left), 32'(0));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},       32'(s_busy),      32'(0));
        check({tag, "_bit_ready"},  32'(s_bit_ready), 32'(0));
        check({tag, "_valid"},      32'(s_valid),     32'(0));
        check({tag, "_data"},       32'(s_data),      32'(0));
        check({tag, "_last"},       32'(s_last),      32'(0));
        check({tag, "_frame_done"}, 32'(s_fdone),     32'(0));
        check({tag, "_sipo_start"}, 32'(s_start | s_sdata), 32'(0));
        check({tag, "_err"},        32'(s_err),       32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed cycle %0d expected completion", cycle);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [W-1:0] f1 [FW] = '{8'hAA, 8'h55, 8'hCC, 8'hF0};
        logic [W-1:0] f2 [FW] = '{8'h0F, 8'h11, 8'h22, 8'h33};
        logic [W-1:0] fr [FW];
        logic [W-1:0] wd_word = 8'hA5;
        int n, t_last, err_cyc, n_err;
        bit saw_valid, err_busy;

        bus.i_frame_start = 1'b0; bus.i_bit_valid = 1'b0; bus.i_bit = 1'b0;
        bus.i_word_ready = 1'b0; bus.i_sipo_done = 1'b0; bus.i_sipo_data = '0;

        rst = 1'b1;
        cyc();
        cyc();
        check_quiet("reset");
        rst = 1'b0;

        run_frame(f1, 0, 1'b0, 0, -1, 0, 1'b0);      // back-to-back, always ready
        run_frame(f1, 0, 1'b0, 0, 1, 5, 1'b0);       // 5-cycle backpressure on word 2
        run_frame(f1, 0, 1'b1, 0, -1, 0, 1'b0);      // alternating bit_valid
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < FW; j++) fr[j] = W'($urandom);
            run_frame(fr, 30, 1'b0, 40, -1, 0, 1'b0);
        end
        run_frame(f1, 20, 1'b0, 20, -1, 0, 1'b1);    // stray frame_start mid-frame

        // Reset after 3 bits of the first word aborts the frame
        bus.i_frame_start = 1'b1;
        cyc();
        bus.i_frame_start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus.i_bit_valid = 1'b1; bus.i_bit = f2[0][b];
            cyc();
        end
        rst = 1'b1; bus.i_bit_valid = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        check_quiet("midreset");
        run_frame(f2, 0, 1'b0, 0, -1, 0, 1'b0);

        // SIPO never answers on the first word
        m_suppress = 1'b1;
        n = 0; t_last = -100; err_cyc = -1; n_err = 0; saw_valid = 1'b0; err_busy = 1'b1;
        bus.i_frame_start = 1'b1;
        cyc();
        bus.i_frame_start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            bus.i_bit_valid = (n < W);
            bus.i_bit = (n < W) ? wd_word[n % W] : 1'b0;
            bus.i_word_ready = 1'b1;
            cyc();
            if (s_bit_ready && bus.i_bit_valid) begin
                n++;
                if (n == W) t_last = s_cyc;
            end
            if (s_valid) saw_valid = 1'b1;
            if (s_err) begin
                n_err++;
                if (err_cyc < 0) begin err_cyc = s_cyc; err_busy = s_busy; end
            end
        end
        check("wdt_bits_accepted", 32'(n), 32'(W));
        check("wdt_no_word", 32'(saw_valid), 32'(0));
`ifdef SIPO_CTRL_WDT_EN
        check("wdt_err_cycle", 32'(err_cyc), 32'(t_last + 1 + TO));
        check("wdt_err_pulses", 32'(n_err), 32'(1));
        check("wdt_err_idle", 32'(err_busy), 32'(0));
        check("wdt_final_busy", 32'(s_busy), 32'(0));
`else
        check("nowdt_err_pulses", 32'(n_err), 32'(0));
        check("nowdt_busy_held", 32'(s_busy), 32'(1));
`endif
        m_suppress = 1'b0;
        rst = 1'b1; bus.i_bit_valid = 1'b0; bus.i_word_ready = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        check_quiet("final_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
